// File: rtl/jtopl_wrseq_pkg.sv
// Shared types and constants for the OPL register-write sequencer.
// FSM encoding, FIFO entry layout and the default chip wait times.
package jtopl_wrseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_AWAIT = 3'd2,
        ST_DATA  = 3'd3,
        ST_DWAIT = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] reg_idx;
        logic [7:0] val;
    } req_t;

    localparam int DEF_ADDR_WAIT = 12;
    localparam int DEF_DATA_WAIT = 84;
    localparam int DEF_FIFO_AW   = 2;

endpackage

// File: rtl/jtopl_wrseq_if.sv
// Request handshake plus chip-side write bus of the write sequencer.
// The master side issues register writes; the slave side is the sequencer.
interface jtopl_wrseq_if;
    logic       req_valid;
    logic [7:0] req_reg;
    logic [7:0] req_val;
    logic       req_ready;
    logic       write;
    logic       addr;
    logic [7:0] dout;
    logic       busy;

    modport master (
        output req_valid, req_reg, req_val,
        input  req_ready, write, addr, dout, busy
    );

    modport slave (
        input  req_valid, req_reg, req_val,
        output req_ready, write, addr, dout, busy
    );
endinterface

// File: rtl/jtopl_wrseq_fifo.sv
// Small synchronous request FIFO; the head entry is readable without a pop
// so the sequencer can capture it in the same clk it pops.
module jtopl_wrseq_fifo
    import jtopl_wrseq_pkg::*;
#(
    parameter int AW = DEF_FIFO_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  req_t        din_i,
    input  logic        pop_i,
    output req_t        dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);
    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    req_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Full/empty guards live here so a misbehaving caller can never corrupt an entry.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/jtopl_wrseq.sv
// OPL register-write sequencer: queues (reg,val) requests and plays them to the
// chip as address strobe, address wait, data strobe, data wait. Optional macro
// JTOPL_WRSEQ_ACACHE_EN skips the address phase when the register is unchanged.
module jtopl_wrseq
    import jtopl_wrseq_pkg::*;
#(
    parameter int ADDR_WAIT = DEF_ADDR_WAIT,
    parameter int DATA_WAIT = DEF_DATA_WAIT,
    parameter int FIFO_AW   = DEF_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    jtopl_wrseq_if.slave  bus
);
    localparam logic [7:0] AWAIT_LOAD = 8'(ADDR_WAIT);
    localparam logic [7:0] DWAIT_LOAD = 8'(DATA_WAIT);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       hold_val_q;
    logic [7:0]       hold_val_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             write_q;
    logic             write_d;
    logic             addr_q;
    logic             addr_d;
    logic [7:0]       dout_q;
    logic [7:0]       dout_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    req_t             fifo_din;
    req_t             fifo_head;
    logic             take_next;
    logic             cache_hit;

    assign fifo_din.reg_idx = bus.req_reg;
    assign fifo_din.val     = bus.req_val;
    assign fifo_push        = bus.req_valid && bus.req_ready;

    jtopl_wrseq_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.req_ready = !fifo_full && !rst;
    assign bus.busy      = !rst && ((state_q != ST_IDLE) || (fifo_count != '0));
    assign bus.write     = write_q;
    assign bus.addr      = addr_q;
    assign bus.dout      = dout_q;

`ifdef JTOPL_WRSEQ_ACACHE_EN
    logic [7:0] last_reg_q;
    logic       cache_vld_q;

    // dout_q carries the register index for the whole ADDR clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg_q  <= 8'd0;
            cache_vld_q <= 1'b0;
        end else if (state_q == ST_ADDR) begin
            last_reg_q  <= dout_q;
            cache_vld_q <= 1'b1;
        end
    end

    assign cache_hit = cache_vld_q && (fifo_head.reg_idx == last_reg_q);
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_val_d = hold_val_q;
        cnt_d      = cnt_q;
        write_d    = 1'b0;
        addr_d     = addr_q;
        dout_d     = dout_q;
        fifo_pop   = 1'b0;
        take_next  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_next = !fifo_empty;
            end
            ST_ADDR: begin
                state_d = ST_AWAIT;
                cnt_d   = AWAIT_LOAD;
            end
            ST_AWAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DATA;
                    write_d = 1'b1;
                    addr_d  = 1'b1;
                    dout_d  = hold_val_q;
                end else if (cen) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DATA: begin
                state_d = ST_DWAIT;
                cnt_d   = DWAIT_LOAD;
            end
            ST_DWAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d   = ST_IDLE;
                    take_next = !fifo_empty;
                end else if (cen) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are launched from registers, so the entering transition sets them up.
        if (take_next) begin
            fifo_pop   = 1'b1;
            hold_val_d = fifo_head.val;
            write_d    = 1'b1;
            if (cache_hit) begin
                state_d = ST_DATA;
                addr_d  = 1'b1;
                dout_d  = fifo_head.val;
            end else begin
                state_d = ST_ADDR;
                addr_d  = 1'b0;
                dout_d  = fifo_head.reg_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_val_q <= 8'd0;
            cnt_q      <= 8'd0;
            write_q    <= 1'b0;
            addr_q     <= 1'b0;
            dout_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            hold_val_q <= hold_val_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
        end
    end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Scoreboard bench for jtopl_wrseq: instance A uses the default waits,
// instance B uses zero waits; monitors compare every write strobe.
module tb_jtopl_wrseq;
    import jtopl_wrseq_pkg::*;

    localparam int AW_A = 12;
    localparam int DW_A = 84;

    typedef struct {
        int   is_data;
        int   dout;
        int   at;
        int   gap;
        int   cens;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, cen_a, cen_b;
    int   cen_mode_a = 0;
    int   cen_mode_b = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_a = -1000;
    int   last_b = -1000;
    int   cens_a = 0;
    int   cens_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   stall, t_idle;

    jtopl_wrseq_if ifa ();
    jtopl_wrseq_if ifb ();

    jtopl_wrseq #(.ADDR_WAIT(AW_A), .DATA_WAIT(DW_A), .FIFO_AW(2)) dut_a (
        .clk (clk), .rst (rst_a), .cen (cen_a), .bus (ifa)
    );

    jtopl_wrseq #(.ADDR_WAIT(0), .DATA_WAIT(0), .FIFO_AW(2)) dut_b (
        .clk (clk), .rst (rst_b), .cen (cen_b), .bus (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
        $fatal(1);
    end

    initial begin
        cen_a = 1'b0;
        cen_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cen_a = (cen_mode_a == 1) || (cen_mode_a == 4 && (cyc % 4) == 0);
            cen_b = (cen_mode_b == 1) || (cen_mode_b == 4 && (cyc % 4) == 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                      name, act, act, exp_v, exp_v, cyc);
    endtask

    task automatic cmp_strobe(input string tag, input exp_t e, input logic a,
                              input logic [7:0] d, input int now, input int last,
                              input int cens);
        $display("strobe %s: cycle %0d addr=%0d dout=0x%02h", tag, now, a, d);
        chk({tag, "_port"}, int'(a), e.is_data);
        chk({tag, "_dout"}, int'(d), e.dout);
        if (e.at >= 0)   chk({tag, "_latency"}, now, e.at);
        if (e.gap >= 0)  chk({tag, "_gap"}, now - last, e.gap);
        if (e.cens >= 0) chk({tag, "_cen_count"}, cens, e.cens);
    endtask

    // Monitor A
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_a && ifa.write) begin
                if (q_a.size() == 0) chk("A_unexpected_strobe", int'(ifa.dout), -1);
                else begin
                    ea = q_a.pop_front();
                    cmp_strobe("A", ea, ifa.addr, ifa.dout, cyc, last_a, cens_a);
                end
                last_a = cyc;
                cens_a = 0;
            end else if (ifa.busy && cen_a) begin
                cens_a++;
            end
        end
    end

    // Monitor B
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_b && ifb.write) begin
                if (q_b.size() == 0) chk("B_unexpected_strobe", int'(ifb.dout), -1);
                else begin
                    eb = q_b.pop_front();
                    cmp_strobe("B", eb, ifb.addr, ifb.dout, cyc, last_b, cens_b);
                end
                last_b = cyc;
                cens_b = 0;
            end else if (ifb.busy && cen_b) begin
                cens_b++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the clk after acceptance.
    task automatic push(input int inst, input logic [7:0] r, input logic [7:0] v,
                        input bit want_a, input bit want_d, input int at_off,
                        input int a_gap, input int d_gap, input int d_cens,
                        output int stall_o);
        bit   acc = 1'b0;
        bit   rdy;
        int   n;
        exp_t e;
        stall_o = 0;
        if (inst == 0) begin
            ifa.req_valid = 1'b1; ifa.req_reg = r; ifa.req_val = v;
        end else begin
            ifb.req_valid = 1'b1; ifb.req_reg = r; ifb.req_val = v;
        end
        while (!acc && stall_o < 1000) begin
            @(negedge clk);
            rdy = (inst == 0) ? ifa.req_ready : ifb.req_ready;
            if (rdy) begin
                acc = 1'b1;
                n = cyc;
                if (want_a) begin
                    e = '{0, int'(r), (at_off >= 0) ? n + at_off : -1, a_gap, -1};
                    if (inst == 0) q_a.push_back(e); else q_b.push_back(e);
                end
                if (want_d) begin
                    e = '{1, int'(v), (!want_a && at_off >= 0) ? n + at_off : -1, d_gap, d_cens};
                    if (inst == 0) q_a.push_back(e); else q_b.push_back(e);
                end
                $display("push %0d: reg=0x%02h val=0x%02h accepted cycle %0d", inst, r, v, n);
            end else begin
                stall_o++;
            end
            @(posedge clk);
            #1;
        end
        if (inst == 0) ifa.req_valid = 1'b0; else ifb.req_valid = 1'b0;
        if (!acc) chk("push_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int inst, input int bound, output int at_cyc);
        bit ok = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (inst == 0 ? (!ifa.busy && q_a.size() == 0) : (!ifb.busy && q_b.size() == 0)) begin
                ok = 1'b1;
                at_cyc = cyc;
            end
        end
        chk(inst == 0 ? "A_reach_idle" : "B_reach_idle", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q_empty(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (q_a.size() == 0) ok = 1'b1;
        end
        chk("A_expected_strobes_seen", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_reg = 8'h77; ifa.req_val = 8'h88;
        ifb.req_valid = 1'b0; ifb.req_reg = 8'h00; ifb.req_val = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_write", int'(ifa.write), 0);
        chk("rst_addr", int'(ifa.addr), 0);
        chk("rst_dout", int'(ifa.dout), 0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_ready_a", int'(ifa.req_ready), 0);
        chk("rst_ready_b", int'(ifb.req_ready), 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.req_valid = 1'b0;
        cen_mode_b = 1;

        // Single request, cen every 4 clk
        cen_mode_a = 4;
        repeat (2) @(posedge clk);
        #1;
        push(0, 8'hA0, 8'h41, 1, 1, 2, -1, -1, AW_A, stall);
        wait_idle(0, 2000, t_idle);
        chk("A_dwait_cen_count", cens_a, DW_A);

        // Six back-to-back requests, cen every clk
        cen_mode_a = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            push(0, 8'(8'h01 + i), 8'(8'h10 + i), 1, 1, (i == 0) ? 2 : -1,
                 (i == 0) ? -1 : DW_A + 2, AW_A + 2, -1, stall);
            chk("A_backpressure_stall", stall, (i < 5) ? 0 : 97);
        end
        wait_idle(0, 2000, t_idle);

        // Reset during AWAIT with a second request still queued
        push(0, 8'h20, 8'h01, 1, 0, 2, -1, -1, -1, stall);
        push(0, 8'h55, 8'h66, 0, 0, -1, -1, -1, -1, stall);
        wait_q_empty(50);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(negedge clk);
        chk("A_abort_ready", int'(ifa.req_ready), 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("A_abort_write", int'(ifa.write), 0);
        chk("A_abort_busy", int'(ifa.busy), 0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("A_after_abort_busy", int'(ifa.busy), 0);
        chk("A_after_abort_ready", int'(ifa.req_ready), 1);
        @(posedge clk);
        #1;

        // Zero waits: one clk per phase
        push(1, 8'hC1, 8'h11, 1, 1, 2, -1, 2, -1, stall);
        push(1, 8'hC2, 8'h22, 1, 1, -1, 2, 2, -1, stall);
        wait_idle(1, 200, t_idle);
        chk("B_idle_after_dwait", t_idle - last_b, 2);

        // Same register twice
        push(1, 8'hB0, 8'h12, 1, 1, -1, -1, 2, -1, stall);
`ifdef JTOPL_WRSEQ_ACACHE_EN
        push(1, 8'hB0, 8'h32, 0, 1, -1, -1, 2, -1, stall);
`else
        push(1, 8'hB0, 8'h32, 1, 1, -1, 2, 2, -1, stall);
`endif
        wait_idle(1, 200, t_idle);

        // cen held low in DWAIT
        push(0, 8'h30, 8'h44, 1, 1, 2, -1, AW_A + 2, -1, stall);
        wait_q_empty(100);
        cen_mode_a = 0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("A_dwait_hold_busy", int'(ifa.busy), 1);
        chk("A_dwait_hold_write", int'(ifa.write), 0);
        @(posedge clk);
        #1;
        cen_mode_a = 1;
        wait_idle(0, 300, t_idle);

        chk("A_queue_drained", q_a.size(), 0);
        chk("B_queue_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtopl_wrseq.md
JTOPL_WRSEQ -- requirements
Module: jtopl_wrseq

Interface
REQ-001 SHALL have parameter ADDR_WAIT, default 12: cen pulses to wait after an address-phase write.
REQ-002 SHALL have parameter DATA_WAIT, default 84: cen pulses to wait after a data-phase write.
REQ-003 SHALL have parameter FIFO_AW, default 2: log2 of request FIFO depth (4 entries).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 cen  input  1  chip clock enable; the wait counters count these pulses.
REQ-007 req_valid  input  1  a register-write request is present.
REQ-008 req_reg  input  8  target register index.
REQ-009 req_val  input  8  value to write.
REQ-010 req_ready  output  1  FIFO can accept a request.
REQ-011 write  output  1  one-clk write strobe to the chip.
REQ-012 addr  output  1  0 selects the address port, 1 the data port.
REQ-013 dout  output  8  chip data bus.
REQ-014 busy  output  1  FSM not IDLE or FIFO not empty.

Function
REQ-015 A request SHALL be accepted on any clk where req_valid and req_ready are both 1; req_ready = !fifo_full && !rst.
REQ-016 FIFO pop SHALL use the registered count only. There is no bypass: a push into an empty FIFO is not poppable in the same clk.
REQ-017 FSM states SHALL be IDLE, ADDR, AWAIT, DATA, DWAIT.
REQ-018 IDLE with FIFO non-empty: pop into holding register, next state ADDR.
REQ-019 ADDR: write=1, addr=0, dout=held reg for exactly one clk, then AWAIT.
REQ-020 AWAIT: 8-bit counter loaded with ADDR_WAIT on entry, decremented per cen. Exit to DATA the clk after the counter is 0. ADDR_WAIT=0 gives one AWAIT clk.
REQ-021 DATA: write=1, addr=1, dout=held val for exactly one clk, then DWAIT.
REQ-022 DWAIT: same counting rule with DATA_WAIT. At exit, if the FIFO is non-empty, pop and go directly to ADDR; otherwise go to IDLE.
REQ-023 Outside ADDR/DATA, write SHALL be 0; addr and dout hold their last driven values.
REQ-024 Latency from an idle, empty FIFO: handshake at clk N gives the address strobe at N+2.
REQ-025 With the FIFO full, req_valid SHALL be ignored and no entry overwritten; a pop frees a slot visible from the next clk.
REQ-026 Requests SHALL be issued strictly in acceptance order.
REQ-027 cen SHALL NOT gate ADDR/DATA strobes; only the wait counters use it.

Reset
REQ-028 During rst: write=0, addr=0, dout=0, busy=0, req_ready=0, FSM=IDLE, FIFO empty, counters 0, cache invalid.
REQ-029 rst mid-operation SHALL abort immediately. Any pending data phase is dropped and write is 0 in the next clk.

Configuration
REQ-030 With JTOPL_WRSEQ_ACACHE_EN defined: last_reg and a valid flag SHALL be updated on each ADDR strobe. A popped request whose reg equals last_reg while valid SHALL skip ADDR/AWAIT and go straight to DATA.
REQ-031 Without JTOPL_WRSEQ_ACACHE_EN: every request SHALL perform the full ADDR, AWAIT, DATA, DWAIT sequence.

Structure
REQ-032 Package jtopl_wrseq_pkg SHALL hold the FSM state encoding and the default ADDR_WAIT/DATA_WAIT constants.
REQ-033 Sub-module jtopl_wrseq_fifo SHALL implement the synchronous FIFO (8+8 bit entries, full/empty/count).

Verification
REQ-034 Reset, then push (0xA0,0x41) with cen every 4 clk. Expect:
- addr strobe dout=0xA0 at N+2;
- data strobe dout=0x41 after 12 cen;
- busy=0 after 84 further cen.
REQ-035 Push 6 requests back-to-back. Expect:
- req_ready=0 after 5 accepted (4 in FIFO + 1 in flight);
- 6th accepted after the first pop;
- all 6 emitted in order, no gaps beyond the waits.
REQ-036 ADDR_WAIT=0, DATA_WAIT=0, cen=1: sequence SHALL be exactly ADDR, AWAIT, DATA, DWAIT, one clk each.
REQ-037 Assert rst during AWAIT of (0x20,0x01): no data strobe follows, FIFO empty, busy=0.
REQ-038 With JTOPL_WRSEQ_ACACHE_EN, push (0xB0,0x12) then (0xB0,0x32): the second request emits only a data strobe. Without the macro, both emit addr+data strobes.
REQ-039 Hold cen=0 in DWAIT: the FSM SHALL stay in DWAIT indefinitely with write=0.
